lazy_summary_scheduler: RTL and testbench

//  Multi-job scheduler for the lazy summary stage. Holds NUM_SLOTS job contexts, issues summary requests
//  (job slot + seq_head_ptr) to the match engine round-robin so one job's feedback latency is hidden by the others.

---
 rtl/lazy_summary_scheduler_pkg.sv | 36 +++
 rtl/sched_sync_fifo.sv | 71 +++++++
 rtl/lazy_summary_scheduler.sv | 238 +++++++++++++++++++++++
 tb/tb_lazy_summary_scheduler.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lazy_summary_scheduler_pkg.sv
// Shared constants and types for the lazy summary scheduler.
//   JOB_LEN_LOG2      width of a job-relative sequence head pointer
//   SEQ_*_BITS        widths of the sequence fields forwarded to the encoder
//   SUMMARY_PIPE_LAT  depth of the match-engine summary pipeline; results still
//                     in it at reset are discarded for this many cycles
//   slot_state_e      per-slot job context state
package lazy_summary_scheduler_pkg;

  localparam int JOB_LEN_LOG2     = 16;
  localparam int SEQ_LL_BITS      = 16;
  localparam int SEQ_ML_BITS      = 16;
  localparam int SEQ_OFFSET_BITS  = 16;
  localparam int SUMMARY_PIPE_LAT = 4;

  typedef enum logic [1:0] {
    SLOT_FREE     = 2'd0,
    SLOT_READY    = 2'd1,
    SLOT_INFLIGHT = 2'd2
  } slot_state_e;

  typedef struct packed {
    logic [SEQ_LL_BITS-1:0]     ll;
    logic [SEQ_ML_BITS-1:0]     ml;
    logic [SEQ_OFFSET_BITS-1:0] offset;
    logic                       eoj;
    logic [SEQ_ML_BITS-1:0]     overlap_len;
  } seq_fields_t;

  localparam int SEQ_FIELDS_W = $bits(seq_fields_t);

  // A zero advance would re-request the same position forever; force +1.
  function automatic logic [JOB_LEN_LOG2-1:0] head_advance(input logic [JOB_LEN_LOG2-1:0] mf);
    return (mf == '0) ? JOB_LEN_LOG2'(1) : mf;
  endfunction

endpackage

// File: rtl/sched_sync_fifo.sv
// Synchronous show-ahead FIFO with occupancy count.
//   clk, rst   clock, synchronous active-high reset
//   i_push     write i_data (ignored when full unless popping the same cycle)
//   i_pop      advance read pointer (ignored when empty)
//   o_data     head entry, valid while !o_empty
//   o_empty    no entries
//   o_count    number of entries, 0..DEPTH
module sched_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full, do_push, do_pop;

  assign o_empty = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = i_pop & ~o_empty;
  // A full FIFO may still take a write when the head leaves in the same cycle.
  assign do_push = i_push & (~full | do_pop);
  assign o_data  = mem_q[rd_q];
  assign o_count = cnt_q;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = i_data;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) rd_d = rd_q + AW'(1);
    if (do_push && !do_pop) cnt_d = cnt_q + CW'(1);
    if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // The owner's credit scheme must make a dropped write impossible.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(i_push && full && !do_pop));
  end

endmodule

// File: rtl/lazy_summary_scheduler.sv
// Multi-job scheduler for the lazy summary stage. Holds NUM_SLOTS job contexts,
// issues (slot, head_ptr) summary requests round-robin so one job's feedback
// latency is hidden behind the others, consumes in-order results, advances head
// pointers and buffers sequences for the sequence encoder.
//   i_job_*        new job offer; o_job_ready when a FREE slot exists
//   o_req_*        summary request to the match engine (valid/ready)
//   i_summary_*    in-order results, no backpressure; i_move_* steer the slot
//   o_seq_*        sequence FIFO head toward the encoder (valid/ready)
//   o_job_done*    one-cycle pulse with the retired job tag
//   o_err_orphan   sticky: result arrived with no outstanding request
// Optional: LAZY_SCHED_PERF_EN adds o_perf_issue_stall / o_perf_seq_count
// (32-bit saturating counters, cleared by rst).
module lazy_summary_scheduler
  import lazy_summary_scheduler_pkg::*;
#(
  parameter int NUM_SLOTS      = 4,
  parameter int SEQ_FIFO_DEPTH = 8,
  parameter int JOB_ID_BITS    = 8,
  localparam int SW            = $clog2(NUM_SLOTS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_job_valid,
  output logic                       o_job_ready,
  input  logic [JOB_ID_BITS-1:0]     i_job_id,
  output logic                       o_req_valid,
  input  logic                       i_req_ready,
  output logic [SW-1:0]              o_req_slot,
  output logic [JOB_LEN_LOG2-1:0]    o_req_head_ptr,
  input  logic                       i_summary_done,
  input  logic                       i_move_to_next_job,
  input  logic [JOB_LEN_LOG2-1:0]    i_move_forward,
  input  logic [SEQ_LL_BITS-1:0]     i_summary_ll,
  input  logic [SEQ_ML_BITS-1:0]     i_summary_ml,
  input  logic [SEQ_OFFSET_BITS-1:0] i_summary_offset,
  input  logic                       i_summary_eoj,
  input  logic [SEQ_ML_BITS-1:0]     i_summary_overlap_len,
  output logic                       o_seq_valid,
  input  logic                       i_seq_ready,
  output logic [JOB_ID_BITS-1:0]     o_seq_job_id,
  output logic [SEQ_LL_BITS-1:0]     o_seq_ll,
  output logic [SEQ_ML_BITS-1:0]     o_seq_ml,
  output logic [SEQ_OFFSET_BITS-1:0] o_seq_offset,
  output logic                       o_seq_eoj,
  output logic [SEQ_ML_BITS-1:0]     o_seq_overlap_len,
  output logic                       o_job_done,
  output logic [JOB_ID_BITS-1:0]     o_job_done_id,
  output logic                       o_err_orphan
`ifdef LAZY_SCHED_PERF_EN
  ,
  output logic [31:0]                o_perf_issue_stall,
  output logic [31:0]                o_perf_seq_count
`endif
);

  localparam int SEQ_W   = JOB_ID_BITS + SEQ_FIELDS_W;
  localparam int FLUSH_W = $clog2(SUMMARY_PIPE_LAT + 1);
  localparam int SCW     = $clog2(SEQ_FIFO_DEPTH) + 1;
  localparam int CRED_W  = SCW + 1;

  slot_state_e             state_q [NUM_SLOTS];
  slot_state_e             state_d [NUM_SLOTS];
  logic [JOB_LEN_LOG2-1:0] head_q  [NUM_SLOTS];
  logic [JOB_LEN_LOG2-1:0] head_d  [NUM_SLOTS];
  logic [JOB_ID_BITS-1:0]  id_q    [NUM_SLOTS];
  logic [JOB_ID_BITS-1:0]  id_d    [NUM_SLOTS];
  logic [SW-1:0]           rr_q, rr_d;
  logic [FLUSH_W-1:0]      flush_q, flush_d;
  logic                    job_done_q, job_done_d;
  logic [JOB_ID_BITS-1:0]  job_done_id_q, job_done_id_d;
  logic                    orphan_q, orphan_d;

  logic                    free_any, grant_any;
  logic [SW-1:0]           free_idx, grant_idx, rr_idx;
  logic                    flush_busy, credit_ok, job_acc, req_fire, res_valid, res_fire;
  logic [SW-1:0]           tag_head;
  logic                    tag_empty;
  logic [SW:0]             tag_count;
  logic [SEQ_W-1:0]        seq_wdata, seq_rdata;
  logic                    seq_empty;
  logic [SCW-1:0]          seq_count;
  seq_fields_t             res_fields;

  // Lowest-index FREE slot takes the next job.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (state_q[i] == SLOT_FREE) begin
        free_any = 1'b1;
        free_idx = SW'(i);
      end
    end
  end

  // Round-robin over READY slots; scanning downward leaves the slot closest to rr_q.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    rr_idx    = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      rr_idx = rr_q + SW'(i);
      if (state_q[rr_idx] == SLOT_READY) begin
        grant_any = 1'b1;
        grant_idx = rr_idx;
      end
    end
  end

  assign flush_busy = (flush_q != '0);
  // Every outstanding request will land a sequence; reserve FIFO room for it
  // up front. Results convert inflight into queued, so credit never shrinks
  // without a handshake and o_req_valid stays asserted until accepted.
  assign credit_ok   = (CRED_W'(seq_count) + CRED_W'(tag_count)) < CRED_W'(SEQ_FIFO_DEPTH);
  assign o_job_ready = free_any & ~flush_busy;
  assign job_acc     = i_job_valid & o_job_ready;
  assign o_req_valid = grant_any & credit_ok;
  assign o_req_slot  = grant_any ? grant_idx : '0;
  assign o_req_head_ptr = grant_any ? head_q[grant_idx] : '0;
  assign req_fire    = o_req_valid & i_req_ready;
  assign res_valid   = i_summary_done & ~flush_busy;
  assign res_fire    = res_valid & ~tag_empty;

  // Results come back in request order, so the tag FIFO alone names the slot.
  sched_sync_fifo #(.WIDTH(SW), .DEPTH(NUM_SLOTS)) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (req_fire),
    .i_data  (grant_idx),
    .i_pop   (res_fire),
    .o_data  (tag_head),
    .o_empty (tag_empty),
    .o_count (tag_count)
  );

  assign res_fields = '{ll: i_summary_ll, ml: i_summary_ml, offset: i_summary_offset,
                        eoj: i_summary_eoj, overlap_len: i_summary_overlap_len};
  assign seq_wdata  = {id_q[tag_head], res_fields};

  sched_sync_fifo #(.WIDTH(SEQ_W), .DEPTH(SEQ_FIFO_DEPTH)) u_seq_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (res_fire),
    .i_data  (seq_wdata),
    .i_pop   (i_seq_ready),
    .o_data  (seq_rdata),
    .o_empty (seq_empty),
    .o_count (seq_count)
  );

  assign o_seq_valid = ~seq_empty;
  assign {o_seq_job_id, o_seq_ll, o_seq_ml, o_seq_offset, o_seq_eoj, o_seq_overlap_len} = seq_rdata;

  // Accept, issue and result always touch different slots (FREE, READY,
  // INFLIGHT respectively), so all three may apply in one cycle.
  always_comb begin
    state_d       = state_q;
    head_d        = head_q;
    id_d          = id_q;
    rr_d          = rr_q;
    flush_d       = flush_busy ? flush_q - FLUSH_W'(1) : flush_q;
    job_done_d    = 1'b0;
    job_done_id_d = job_done_id_q;
    orphan_d      = orphan_q | (res_valid & tag_empty);
    if (job_acc) begin
      state_d[free_idx] = SLOT_READY;
      head_d[free_idx]  = '0;
      id_d[free_idx]    = i_job_id;
    end
    if (req_fire) begin
      state_d[grant_idx] = SLOT_INFLIGHT;
      rr_d               = grant_idx + SW'(1);
    end
    if (res_fire) begin
      if (i_move_to_next_job) begin
        state_d[tag_head] = SLOT_FREE;
        job_done_d        = 1'b1;
        job_done_id_d     = id_q[tag_head];
      end else begin
        state_d[tag_head] = SLOT_READY;
        head_d[tag_head]  = head_q[tag_head] + head_advance(i_move_forward);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= SLOT_FREE;
        head_q[i]  <= '0;
        id_q[i]    <= '0;
      end
      rr_q          <= '0;
      flush_q       <= FLUSH_W'(SUMMARY_PIPE_LAT);
      job_done_q    <= 1'b0;
      job_done_id_q <= '0;
      orphan_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      id_q          <= id_d;
      rr_q          <= rr_d;
      flush_q       <= flush_d;
      job_done_q    <= job_done_d;
      job_done_id_q <= job_done_id_d;
      orphan_q      <= orphan_d;
    end
  end

  assign o_job_done    = job_done_q;
  assign o_job_done_id = job_done_id_q;
  assign o_err_orphan  = orphan_q;

`ifdef LAZY_SCHED_PERF_EN
  logic [31:0] stall_q, stall_d, seqcnt_q, seqcnt_d;

  always_comb begin
    stall_d  = stall_q;
    seqcnt_d = seqcnt_q;
    if (grant_any && !(credit_ok && i_req_ready) && stall_q != '1) stall_d = stall_q + 32'd1;
    if (res_fire && seqcnt_q != '1) seqcnt_d = seqcnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      seqcnt_q <= '0;
    end else begin
      stall_q  <= stall_d;
      seqcnt_q <= seqcnt_d;
    end
  end

  assign o_perf_issue_stall = stall_q;
  assign o_perf_seq_count   = seqcnt_q;
`endif

endmodule

// File: tb/tb_lazy_summary_scheduler.sv
// Self-checking bench for lazy_summary_scheduler: directed scenarios plus a
// randomized run against a slot/queue reference model.
module tb_lazy_summary_scheduler;
  import lazy_summary_scheduler_pkg::*;

  localparam int NS    = 4;
  localparam int DEPTH = 8;
  localparam int IDW   = 8;
  localparam int SW    = 2;
  localparam int SEQ_W = IDW + SEQ_LL_BITS + 2 * SEQ_ML_BITS + SEQ_OFFSET_BITS + 1;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       i_job_valid, i_req_ready, i_summary_done, i_move_to_next_job;
  logic                       i_seq_ready, i_summary_eoj;
  logic [IDW-1:0]             i_job_id;
  logic [JOB_LEN_LOG2-1:0]    i_move_forward;
  logic [SEQ_LL_BITS-1:0]     i_summary_ll;
  logic [SEQ_ML_BITS-1:0]     i_summary_ml, i_summary_overlap_len;
  logic [SEQ_OFFSET_BITS-1:0] i_summary_offset;
  logic                       o_job_ready, o_req_valid, o_seq_valid, o_seq_eoj, o_job_done, o_err_orphan;
  logic [SW-1:0]              o_req_slot;
  logic [JOB_LEN_LOG2-1:0]    o_req_head_ptr;
  logic [IDW-1:0]             o_seq_job_id, o_job_done_id;
  logic [SEQ_LL_BITS-1:0]     o_seq_ll;
  logic [SEQ_ML_BITS-1:0]     o_seq_ml, o_seq_overlap_len;
  logic [SEQ_OFFSET_BITS-1:0] o_seq_offset;
`ifdef LAZY_SCHED_PERF_EN
  logic [31:0]                o_perf_issue_stall, o_perf_seq_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lazy_summary_scheduler #(.NUM_SLOTS(NS), .SEQ_FIFO_DEPTH(DEPTH), .JOB_ID_BITS(IDW)) dut (
    .clk(clk), .rst(rst),
    .i_job_valid(i_job_valid), .o_job_ready(o_job_ready), .i_job_id(i_job_id),
    .o_req_valid(o_req_valid), .i_req_ready(i_req_ready), .o_req_slot(o_req_slot),
    .o_req_head_ptr(o_req_head_ptr),
    .i_summary_done(i_summary_done), .i_move_to_next_job(i_move_to_next_job),
    .i_move_forward(i_move_forward), .i_summary_ll(i_summary_ll), .i_summary_ml(i_summary_ml),
    .i_summary_offset(i_summary_offset), .i_summary_eoj(i_summary_eoj),
    .i_summary_overlap_len(i_summary_overlap_len),
    .o_seq_valid(o_seq_valid), .i_seq_ready(i_seq_ready), .o_seq_job_id(o_seq_job_id),
    .o_seq_ll(o_seq_ll), .o_seq_ml(o_seq_ml), .o_seq_offset(o_seq_offset),
    .o_seq_eoj(o_seq_eoj), .o_seq_overlap_len(o_seq_overlap_len),
    .o_job_done(o_job_done), .o_job_done_id(o_job_done_id), .o_err_orphan(o_err_orphan)
`ifdef LAZY_SCHED_PERF_EN
    , .o_perf_issue_stall(o_perf_issue_stall), .o_perf_seq_count(o_perf_seq_count)
`endif
  );

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_job_valid = 0; i_job_id = '0; i_req_ready = 0; i_summary_done = 0;
    i_move_to_next_job = 0; i_move_forward = '0; i_summary_ll = '0; i_summary_ml = '0;
    i_summary_offset = '0; i_summary_eoj = 0; i_summary_overlap_len = '0; i_seq_ready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    nxt();
    nxt();
    rst = 0;
  endtask

  task automatic wait_flush();
    repeat (SUMMARY_PIPE_LAT) nxt();
  endtask

  // Fields derive from base so each result is distinguishable downstream.
  task automatic send_result(input logic [JOB_LEN_LOG2-1:0] mf, input logic nj, input logic [15:0] base);
    i_summary_done = 1; i_move_forward = mf; i_move_to_next_job = nj;
    i_summary_ll = base; i_summary_ml = base + 16'd1; i_summary_offset = base + 16'd2;
    i_summary_eoj = nj; i_summary_overlap_len = base + 16'd3;
    nxt();
    i_summary_done = 0; i_move_to_next_job = 0;
  endtask

  task automatic accept_jobs(input int n, input logic [IDW-1:0] base_id, output logic ok);
    ok = 1;
    for (int j = 0; j < n; j++) begin
      logic got = 0;
      i_job_valid = 1; i_job_id = base_id + IDW'(j);
      for (int k = 0; k < 20 && !got; k++) begin
        #1;
        if (o_job_ready) got = 1;
        nxt();
      end
      if (!got) ok = 0;
    end
    i_job_valid = 0;
  endtask

  task automatic issue_one(output logic ok, output logic [SW-1:0] slot, output logic [JOB_LEN_LOG2-1:0] head);
    ok = 0; slot = '0; head = '0;
    for (int k = 0; k < 20 && !ok; k++) begin
      #1;
      if (o_req_valid) begin
        ok = 1; slot = o_req_slot; head = o_req_head_ptr; i_req_ready = 1;
      end
      nxt();
      i_req_ready = 0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if ({o_job_ready, o_req_valid, o_req_slot, o_req_head_ptr, o_seq_valid, o_job_done,
         o_job_done_id, o_err_orphan, o_seq_job_id, o_seq_ll} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: some output nonzero after reset, required all 0");
    end
    for (int k = 0; k < SUMMARY_PIPE_LAT; k++) begin
      n_checks++;
      if (o_job_ready !== 1'b0) begin n_fail++; $display("FAIL flush_job_ready[%0d]: got %b required 0", k, o_job_ready); end
      nxt();
    end
    n_checks++;
    if (o_job_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_flush: got %b required 1", o_job_ready); end
  endtask

  task automatic test_single_job();
    logic ok;
    logic [SW-1:0] s;
    logic [JOB_LEN_LOG2-1:0] h;
    logic [JOB_LEN_LOG2-1:0] exp_h[3] = '{16'd0, 16'd7, 16'd16};
    logic [JOB_LEN_LOG2-1:0] mfs[3]   = '{16'd7, 16'd9, 16'd3};
    do_reset(); wait_flush();
    accept_jobs(1, 8'd5, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_accept: job not accepted"); end
    for (int r = 0; r < 3; r++) begin
      issue_one(ok, s, h);
      n_checks++;
      if (!ok || s !== 2'd0 || h !== exp_h[r]) begin
        n_fail++; $display("FAIL single_req[%0d]: ok=%b slot=%0d head=%0d required slot=0 head=%0d", r, ok, s, h, exp_h[r]);
      end
      send_result(mfs[r], r == 2, 16'(100 * (r + 1)));
    end
    #1;
    n_checks++;
    if (o_job_done !== 1'b1 || o_job_done_id !== 8'd5) begin
      n_fail++; $display("FAIL single_done: done=%b id=%0d required 1/5", o_job_done, o_job_done_id);
    end
    nxt();
    n_checks++;
    if (o_job_done !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got %b required 0", o_job_done); end
    i_seq_ready = 1;
    for (int r = 0; r < 3; r++) begin
      logic [15:0] b;
      b = 16'(100 * (r + 1));
      #1;
      n_checks++;
      if (o_seq_valid !== 1'b1 || o_seq_job_id !== 8'd5 || o_seq_ll !== b || o_seq_ml !== b + 16'd1 ||
          o_seq_offset !== b + 16'd2 || o_seq_eoj !== (r == 2) || o_seq_overlap_len !== b + 16'd3) begin
        n_fail++; $display("FAIL single_seq[%0d]: v=%b id=%0d ll=%0d ml=%0d off=%0d eoj=%b ovl=%0d required id=5 ll=%0d",
                           r, o_seq_valid, o_seq_job_id, o_seq_ll, o_seq_ml, o_seq_offset, o_seq_eoj, o_seq_overlap_len, b);
      end
      nxt();
    end
    #1;
    n_checks++;
    if (o_seq_valid !== 1'b0 || o_req_valid !== 1'b0 || o_job_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_idle: seq_valid=%b req_valid=%b job_ready=%b required 0/0/1", o_seq_valid, o_req_valid, o_job_ready);
    end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic ok;
    int due[$];
    int n = 0;
    do_reset(); wait_flush();
    accept_jobs(4, 8'd10, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rr_accept: jobs not accepted"); end
    i_seq_ready = 1;
    for (int c = 0; c < 40; c++) begin
      i_summary_done = 0;
      if (due.size() > 0 && due[0] <= c) begin
        void'(due.pop_front());
        i_summary_done = 1; i_move_forward = 16'd1; i_move_to_next_job = 0;
      end
      i_req_ready = 1;
      #1;
      if (o_req_valid) begin
        n_checks++;
        if (o_req_slot !== SW'(n % NS) || o_req_head_ptr !== JOB_LEN_LOG2'(n / NS)) begin
          n_fail++; $display("FAIL rr_grant[%0d]: slot=%0d head=%0d required slot=%0d head=%0d", n, o_req_slot, o_req_head_ptr, n % NS, n / NS);
        end
        n++;
        due.push_back(c + SUMMARY_PIPE_LAT);
      end
      nxt();
    end
    clear_inputs();
    n_checks++;
    if (n < 24) begin n_fail++; $display("FAIL rr_count: got %0d grants required at least 24", n); end
  endtask

  task automatic test_backpressure();
    logic ok;
    int due[$];
    int slots[$];
    int n = 0;
    do_reset(); wait_flush();
    accept_jobs(4, 8'd20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bp_accept: jobs not accepted"); end
    for (int c = 0; c < 60; c++) begin
      i_summary_done = 0;
      if (due.size() > 0 && due[0] <= c) begin
        void'(due.pop_front());
        i_summary_done = 1; i_move_forward = 16'd3; i_move_to_next_job = 0;
      end
      i_req_ready = 1;
      #1;
      if (o_req_valid) begin
        slots.push_back(int'(o_req_slot)); n++; due.push_back(c + SUMMARY_PIPE_LAT);
      end
      nxt();
    end
    clear_inputs();
    #1;
    n_checks++;
    if (n !== DEPTH || o_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_issue_limit: issued=%0d req_valid=%b required %0d/0", n, o_req_valid, DEPTH);
    end
    i_seq_ready = 1;
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      n_checks++;
      if (o_seq_valid !== 1'b1 || o_seq_job_id !== IDW'(20 + (k % NS))) begin
        n_fail++; $display("FAIL bp_drain[%0d]: v=%b id=%0d required 1/%0d", k, o_seq_valid, o_seq_job_id, 20 + (k % NS));
      end
      nxt();
    end
    #1;
    n_checks++;
    if (o_seq_valid !== 1'b0 || o_req_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_after_drain: seq_valid=%b req_valid=%b required 0/1", o_seq_valid, o_req_valid);
    end
    clear_inputs();
  endtask

  task automatic test_zero_progress();
    logic ok;
    logic [SW-1:0] s;
    logic [JOB_LEN_LOG2-1:0] h;
    logic [JOB_LEN_LOG2-1:0] mfs[3]   = '{16'd5, 16'd0, 16'd0};
    logic [JOB_LEN_LOG2-1:0] exp_h[4] = '{16'd0, 16'd5, 16'd6, 16'd7};
    do_reset(); wait_flush();
    accept_jobs(1, 8'd7, ok);
    i_seq_ready = 1;
    for (int r = 0; r < 4; r++) begin
      issue_one(ok, s, h);
      n_checks++;
      if (!ok || h !== exp_h[r]) begin
        n_fail++; $display("FAIL zero_progress[%0d]: ok=%b head=%0d required %0d", r, ok, h, exp_h[r]);
      end
      if (r < 3) send_result(mfs[r], 1'b0, 16'd1);
    end
    clear_inputs();
  endtask

  task automatic test_reset_midflight();
    logic ok;
    logic [SW-1:0] s;
    logic [JOB_LEN_LOG2-1:0] h;
    do_reset(); wait_flush();
    accept_jobs(3, 8'd40, ok);
    for (int r = 0; r < 3; r++) issue_one(ok, s, h);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      i_summary_done = 1; i_move_to_next_job = (k == 2); i_move_forward = 16'd4;
      #1;
      n_checks++;
      if (o_seq_valid !== 1'b0 || o_job_done !== 1'b0 || o_err_orphan !== 1'b0) begin
        n_fail++; $display("FAIL midflight_flush[%0d]: seq_valid=%b done=%b orphan=%b required 0/0/0", k, o_seq_valid, o_job_done, o_err_orphan);
      end
      nxt();
    end
    clear_inputs();
    nxt();
    #1;
    n_checks++;
    if (o_seq_valid !== 1'b0 || o_job_done !== 1'b0 || o_err_orphan !== 1'b0 ||
        o_job_ready !== 1'b1 || o_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL midflight_after: seq_valid=%b done=%b orphan=%b job_ready=%b req_valid=%b required 0/0/0/1/0",
                         o_seq_valid, o_job_done, o_err_orphan, o_job_ready, o_req_valid);
    end
  endtask

  task automatic test_orphan();
    do_reset(); wait_flush();
    #1;
    n_checks++;
    if (o_err_orphan !== 1'b0) begin n_fail++; $display("FAIL orphan_pre: got %b required 0", o_err_orphan); end
    send_result(16'd2, 1'b0, 16'd9);
    #1;
    n_checks++;
    if (o_err_orphan !== 1'b1 || o_seq_valid !== 1'b0 || o_job_done !== 1'b0) begin
      n_fail++; $display("FAIL orphan_set: orphan=%b seq_valid=%b done=%b required 1/0/0", o_err_orphan, o_seq_valid, o_job_done);
    end
    repeat (5) nxt();
    n_checks++;
    if (o_err_orphan !== 1'b1) begin n_fail++; $display("FAIL orphan_sticky: got %b required 1", o_err_orphan); end
    do_reset();
    #1;
    n_checks++;
    if (o_err_orphan !== 1'b0) begin n_fail++; $display("FAIL orphan_clear: got %b required 0", o_err_orphan); end
  endtask

  // Reference model: slot occupancy, heads and RR pointer as plain arrays; the
  // match engine is a queue of due times; expected sequences in a queue.
  task automatic test_random();
    int m_state[NS];                 // 0 free, 1 ready, 2 inflight
    logic [JOB_LEN_LOG2-1:0] m_head[NS];
    logic [IDW-1:0] m_id[NS];
    int m_rr = 0;
    int m_inflight[$];
    int due[$];
    logic [SEQ_W-1:0] exp_seq[$];
    logic exp_done = 0;
    logic [IDW-1:0] exp_done_id = '0;
    do_reset(); wait_flush();
    for (int i = 0; i < NS; i++) begin m_state[i] = 0; m_head[i] = '0; m_id[i] = '0; end
    for (int c = 0; c < 1500; c++) begin
      int eg, ef;
      logic fire_res, exp_ready, exp_rv;
      i_job_valid = ($urandom_range(0, 3) == 0); i_job_id = IDW'($urandom);
      i_req_ready = ($urandom_range(0, 3) != 0);
      i_seq_ready = ($urandom_range(0, 2) != 0);
      fire_res = (due.size() > 0 && due[0] <= c);
      i_summary_done = fire_res;
      i_move_forward = ($urandom_range(0, 3) == 0) ? '0 : JOB_LEN_LOG2'($urandom);
      i_move_to_next_job = ($urandom_range(0, 4) == 0);
      i_summary_ll = 16'($urandom); i_summary_ml = 16'($urandom); i_summary_offset = 16'($urandom);
      i_summary_eoj = 1'($urandom); i_summary_overlap_len = 16'($urandom);
      #1;
      ef = -1; eg = -1;
      for (int i = NS - 1; i >= 0; i--) begin
        if (m_state[i] == 0) ef = i;
        if (m_state[(m_rr + i) % NS] == 1) eg = (m_rr + i) % NS;
      end
      exp_ready = (ef >= 0);
      exp_rv = (eg >= 0) && (exp_seq.size() + m_inflight.size() < DEPTH);
      n_checks++;
      if (o_job_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_job_ready@%0d: got %b required %b", c, o_job_ready, exp_ready); end
      n_checks++;
      if (o_job_done !== exp_done || (exp_done && o_job_done_id !== exp_done_id)) begin
        n_fail++; $display("FAIL rnd_done@%0d: done=%b id=%0d required %b/%0d", c, o_job_done, o_job_done_id, exp_done, exp_done_id);
      end
      n_checks++;
      if (o_req_valid !== exp_rv || (exp_rv && (o_req_slot !== SW'(eg) || o_req_head_ptr !== m_head[eg]))) begin
        n_fail++; $display("FAIL rnd_req@%0d: v=%b slot=%0d head=%0d required v=%b slot=%0d head=%0d",
                           c, o_req_valid, o_req_slot, o_req_head_ptr, exp_rv, eg, (eg >= 0) ? m_head[eg] : '0);
      end
      n_checks++;
      if (o_seq_valid !== (exp_seq.size() > 0) ||
          (exp_seq.size() > 0 && {o_seq_job_id, o_seq_ll, o_seq_ml, o_seq_offset, o_seq_eoj, o_seq_overlap_len} !== exp_seq[0])) begin
        n_fail++; $display("FAIL rnd_seq@%0d: v=%b id=%0d ll=%0h required v=%b", c, o_seq_valid, o_seq_job_id, o_seq_ll, exp_seq.size() > 0);
      end
      // Model update for the coming edge.
      exp_done = 0;
      if (exp_seq.size() > 0 && i_seq_ready) void'(exp_seq.pop_front());
      if (i_job_valid && exp_ready) begin m_state[ef] = 1; m_head[ef] = '0; m_id[ef] = i_job_id; end
      if (exp_rv && i_req_ready) begin
        m_state[eg] = 2; m_inflight.push_back(eg); due.push_back(c + int'($urandom_range(1, 6)));
        m_rr = (eg + 1) % NS;
      end
      if (fire_res) begin
        int s;
        s = m_inflight.pop_front();
        void'(due.pop_front());
        exp_seq.push_back({m_id[s], i_summary_ll, i_summary_ml, i_summary_offset, i_summary_eoj, i_summary_overlap_len});
        if (i_move_to_next_job) begin
          m_state[s] = 0; exp_done = 1; exp_done_id = m_id[s];
        end else begin
          m_state[s] = 1; m_head[s] = m_head[s] + ((i_move_forward == '0) ? JOB_LEN_LOG2'(1) : i_move_forward);
        end
      end
      nxt();
    end
    clear_inputs();
    #1;
    n_checks++;
    if (o_err_orphan !== 1'b0) begin n_fail++; $display("FAIL rnd_orphan: got %b required 0", o_err_orphan); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_single_job();
    test_round_robin();
    test_backpressure();
    test_zero_progress();
    test_reset_midflight();
    test_orphan();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
